// File: rtl/snes_clock_reset_seq.sv
// Power-on sequencer for the SNES core: qualifies PLL lock, waits out the POR
// delay, handshakes SDRAM init, then releases core reset and runs the ce strobe.
module snes_clock_reset_seq #(
  parameter int POR_CYCLES  = 17280,
  parameter int LOCK_FILTER = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int CE_DIV      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       sdram_init_done,
  input  logic       pause,
  output logic       sdram_init_req,
  output logic       snes_reset,
  output logic       ce,
  output logic [3:0] ce_phase,
  output logic       ready,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_WAIT_LOCK = 3'd0,
    S_POR       = 3'd1,
    S_INIT      = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam logic [7:0]  FILT_MAX  = 8'(LOCK_FILTER);
  localparam logic [19:0] POR_LAST  = 20'(POR_CYCLES - 1);
  localparam logic [15:0] HOLD_MAX  = 16'(HOLD_CYCLES);
  localparam logic [3:0]  PHASE_MAX = 4'(CE_DIV - 1);

  state_t      state_q, state_d;
  logic        sync1_q, lock_s;
  logic [7:0]  filt_cnt;
  logic        lock_ok;
  logic [19:0] por_cnt;
  logic [15:0] hold_cnt;
  logic        ce_active;

  // Two-flop synchronizer for the asynchronous PLL lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      lock_s  <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      lock_s  <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !lock_s)
      filt_cnt <= 8'd0;
    else if (filt_cnt != FILT_MAX)
      filt_cnt <= filt_cnt + 8'd1;
  end

  // A low lock_s drops lock_ok immediately, before the counter clears.
  assign lock_ok = lock_s && (filt_cnt == FILT_MAX);

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_WAIT_LOCK;
    else
      state_q <= state_d;
  end

  // sdram_init_req/sdram_init_done is a level handshake: req stays high for
  // as long as the FSM sits in INIT, and done is only looked at while there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_LOCK: if (lock_ok) state_d = S_POR;
      S_POR:       if (por_cnt == POR_LAST) state_d = S_INIT;
      S_INIT:      if (sdram_init_done) state_d = S_HOLD;
      S_HOLD:      if (hold_cnt == HOLD_MAX) state_d = S_RUN;
      S_RUN:       state_d = S_RUN;
      default:     state_d = S_WAIT_LOCK;
    endcase
    if (state_q != S_WAIT_LOCK && !lock_ok)
      state_d = S_WAIT_LOCK;
  end

  always_ff @(posedge clk) begin
    if (reset || state_q != S_POR)
      por_cnt <= 20'd0;
    else
      por_cnt <= por_cnt + 20'd1;
  end

  always_ff @(posedge clk) begin
    if (reset || state_q != S_HOLD)
      hold_cnt <= 16'd0;
    else if (ce)
      hold_cnt <= hold_cnt + 16'd1;
  end

  assign ce_active = (state_q == S_HOLD) || (state_q == S_RUN);

  // Pause is only honoured at phase 0, so a started period always completes.
  always_ff @(posedge clk) begin
    if (reset || !ce_active) begin
      ce_phase <= 4'd0;
      ce       <= 1'b0;
    end else begin
      ce <= (ce_phase == PHASE_MAX);
      if (ce_phase == PHASE_MAX)
        ce_phase <= 4'd0;
      else if (ce_phase == 4'd0 && pause)
        ce_phase <= 4'd0;
      else
        ce_phase <= ce_phase + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sdram_init_req <= 1'b0;
      snes_reset     <= 1'b1;
      ready          <= 1'b0;
    end else begin
      sdram_init_req <= (state_q == S_INIT);
      snes_reset     <= (state_q != S_RUN);
      ready          <= (state_q == S_RUN);
    end
  end

  assign state_dbg = state_q;

endmodule
